mem_stage_mmio: RTL and testbench
=================================

Name: mem_stage_mmio

Overview:
- Parametrised data-memory pipeline stage between execute and writeback.
- Performs LDW/STW on a word-addressed data RAM with configurable read latency.
- Decodes memory-mapped LEDR/LEDG/HEX registers and computes load condition codes.
- Uses a valid/stall handshake in both directions.

Parameters:
DATA_W, 16, data/register width
DEPTH, 1024, data RAM words; address width AW = clog2(DEPTH)
READ_LAT, 2, extra cycles a RAM load occupies (0..15)
NUM_HEX, 4, seven-segment digits; HEX register width = 4*NUM_HEX
ADDR_LEDR, 16'h03FC, byte address of LEDR register
ADDR_LEDG, 16'h03FD, byte address of LEDG register
ADDR_HEX, 16'h03FE, byte address of HEX register
HEX_RST, 16'hBFFF, HEX register reset value
INIT_FILE, "data.hex", $readmemh image for the RAM

Ports:
I_CLOCK  in  1  stage clock; all state updates on negedge
I_RESET  in  1  asynchronous, active-high reset
I_Valid  in  1  execute stage presents an instruction
I_Opcode  in  OPCODE_WIDTH  opcode
I_DestRegIdx  in  4  destination register index
I_DestValue  in  DATA_W  ALU result
I_CCValue  in  3  condition code from execute
I_MARValue  in  DATA_W  byte address
I_MDRValue  in  DATA_W  store data
I_RegWEn  in  1  register write enable
I_CCWEn  in  1  condition-code write enable
I_DownStall  in  1  writeback cannot accept
O_Stall  out  1  upstream must hold its inputs
O_Valid  out  1  outputs carry an instruction
O_Opcode  out  OPCODE_WIDTH  forwarded opcode
O_DestRegIdx  out  4  forwarded destination index
O_DestValue  out  DATA_W  load data or forwarded ALU value
O_CCValue  out  3  condition code
O_RegWEn  out  1  gated by O_Valid
O_CCWEn  out  1  gated by O_Valid
O_AddrErr  out  1  sticky out-of-range access flag
O_LEDR  out  10  LEDR register
O_LEDG  out  8  LEDG register
O_HEX  out  7*NUM_HEX  decoded digits; digit 0 = bits [6:0] = nibble [3:0]

Behaviour:
- Reset (asynchronous):
  - O_Valid, O_RegWEn, O_CCWEn, O_AddrErr = 0.
  - O_DestValue = 0; O_CCValue = CC_Z.
  - LEDR = 10'h3FF, LEDG = 8'hFF, HEX = HEX_RST.
  - FSM goes to RUN. RAM contents are not reset.
- Word address = MAR >> 1.
- An address is MMIO if MAR equals one of the three ADDR_* values. A non-MMIO address is out-of-range if its word address >= DEPTH.
- Accept condition: I_Valid && !O_Stall, sampled at the negedge.
- O_Stall (combinational) = (state == WAIT) || (O_Valid && I_DownStall).
- While O_Valid && I_DownStall, all outputs hold and nothing is accepted.
- FSM has two states, RUN and WAIT.
- RUN, accepting a non-load, an MMIO load, or any load with READ_LAT = 0:
  - Outputs register at the same edge; O_Valid = 1 after that edge.
  - Single-cycle throughput.
- RUN, accepting a RAM load with READ_LAT = L > 0:
  - Latch the instruction fields and word address; counter = L.
  - Go to WAIT; O_Valid = 0 after that edge.
- WAIT:
  - Counter decrements each edge.
  - On the edge where the counter reaches 0: register RAM data, O_Valid = 1, return to RUN.
  - Net effect: a load accepted at edge N presents its result after edge N+L, with L bubbles.
- STW:
  - MMIO: writes the low bits of MDR into LEDR[9:0], LEDG[7:0] or HEX[4*NUM_HEX-1:0]; RAM is untouched.
  - Otherwise writes RAM at the accept edge.
  - O_RegWEn = 0 regardless of I_RegWEn. O_CCValue and O_CCWEn are forwarded.
- LDW:
  - O_DestValue = RAM word, or the zero-extended MMIO register value.
  - O_CCValue = CC_N if MSB is set, CC_Z if the value is 0, else CC_P. O_CCWEn = 1.
- Other opcodes forward DestValue, CC, RegWEn and CCWEn unchanged.
- Out-of-range access:
  - A store is dropped; a load returns 0 with CC_Z.
  - O_AddrErr sets and stays set until reset.
- Store followed by a load of the same address returns the new data (the write commits before the load is accepted).
- Reset asserted during WAIT aborts the load; no output is produced.

Decomposition:
- Shared package/header (global_def.h):
  - OP_LDW and OP_STW opcodes, CC_N/CC_Z/CC_P encodings, OPCODE_WIDTH.
  - Default MMIO addresses, FSM state encoding.
- Sub-module mmio_regs:
  - Holds the LEDR/LEDG/HEX registers, the address decode and the read mux.
  - Instantiates the existing SevenSeg module NUM_HEX times.

Test Plan:
- Reset check: assert I_RESET mid-WAIT -> O_Valid = 0, O_LEDR = 3FF, O_LEDG = FF, HEX register = BFFF, O_Stall = 0 immediately.
- Store/load, READ_LAT = 2: STW MAR = 0x0010, MDR = 0x8001, then LDW 0x0010 -> O_Stall high for 2 edges, then O_DestValue = 0x8001, O_CCValue = CC_N, O_CCWEn = 1.
- Load of zero: LDW of a word holding 0x0000 -> CC_Z; a word holding 0x7FFF -> CC_P.
- MMIO: STW MAR = 0x03FE, MDR = 0x1234 -> O_HEX digit 0 shows "4", digit 3 shows "1", RAM word 0x1FF unchanged; LDW 0x03FE -> 0x1234 with no bubbles.
- Backpressure: ADD valid with I_DownStall = 1 for 3 cycles -> outputs frozen, O_Stall = 1, next instruction accepted on the first edge after release.
- Out-of-range with DEPTH = 256: STW to MAR = 0x0400 -> no RAM change, O_AddrErr = 1 sticky; following LDW there -> 0, CC_Z.

Source files
------------

// File: rtl/mem_stage_mmio_pkg.sv
// mem_stage_mmio_pkg: opcodes, condition codes, default MMIO addresses and FSM states
package mem_stage_mmio_pkg;
   localparam int OPCODE_WIDTH = 4;
   localparam logic [OPCODE_WIDTH-1:0] OP_LDW = 4'd6;
   localparam logic [OPCODE_WIDTH-1:0] OP_STW = 4'd7;
   localparam logic [2:0] CC_N = 3'b100, CC_Z = 3'b010, CC_P = 3'b001;
   localparam logic [15:0] DEF_ADDR_LEDR = 16'h03FC;
   localparam logic [15:0] DEF_ADDR_LEDG = 16'h03FD;
   localparam logic [15:0] DEF_ADDR_HEX = 16'h03FE;
   typedef enum logic {ST_RUN, ST_WAIT} state_t;
endpackage

// File: rtl/mem_stage_mmio_regs.sv
// mem_stage_mmio_regs: LEDR/LEDG/HEX registers, address decode, read mux and digit decode
module mem_stage_mmio_regs
   import mem_stage_mmio_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int NUM_HEX = 4,
   parameter logic [DATA_W-1:0] ADDR_LEDR = DATA_W'(DEF_ADDR_LEDR),
   parameter logic [DATA_W-1:0] ADDR_LEDG = DATA_W'(DEF_ADDR_LEDG),
   parameter logic [DATA_W-1:0] ADDR_HEX = DATA_W'(DEF_ADDR_HEX),
   parameter logic [4*NUM_HEX-1:0] HEX_RST = (4*NUM_HEX)'(16'hBFFF)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [DATA_W-1:0]    addr,
   input  logic [DATA_W-1:0]    wdata,
   output logic                 hit,
   output logic [DATA_W-1:0]    rdata,
   output logic [9:0]           ledr,
   output logic [7:0]           ledg,
   output logic [7*NUM_HEX-1:0] hex
);
   logic [4*NUM_HEX-1:0] hex_q;
   logic hit_r, hit_g, hit_h;
   assign hit_r = addr == ADDR_LEDR;
   assign hit_g = addr == ADDR_LEDG;
   assign hit_h = addr == ADDR_HEX;
   assign hit = hit_r || hit_g || hit_h;
   assign rdata = hit_r ? DATA_W'(ledr) : hit_g ? DATA_W'(ledg) : hit_h ? DATA_W'(hex_q) : '0;
   always_ff @(negedge clk or posedge rst)
      if (rst) begin
         ledr <= '1;
         ledg <= '1;
         hex_q <= HEX_RST;
      end else if (we) begin
         if (hit_r) ledr <= wdata[9:0];
         if (hit_g) ledg <= wdata[7:0];
         if (hit_h) hex_q <= wdata[4*NUM_HEX-1:0];
      end
   for (genvar g = 0; g < NUM_HEX; g++) begin : g_dig
      seven_seg u_seg (.nib(hex_q[4*g +: 4]), .seg(hex[7*g +: 7]));
   end
endmodule

// File: rtl/seven_seg.sv
// seven_seg: hex nibble to active-low segments, bit order gfedcba
module seven_seg (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   always_comb
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
      endcase
endmodule

// File: rtl/mem_stage_mmio.sv
// mem_stage_mmio: data-memory pipeline stage with word RAM, multi-cycle loads
// and memory-mapped LED/HEX registers; all state changes on the falling clock edge.
module mem_stage_mmio
   import mem_stage_mmio_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int DEPTH = 1024,
   parameter int READ_LAT = 2,
   parameter int NUM_HEX = 4,
   parameter logic [DATA_W-1:0] ADDR_LEDR = DATA_W'(DEF_ADDR_LEDR),
   parameter logic [DATA_W-1:0] ADDR_LEDG = DATA_W'(DEF_ADDR_LEDG),
   parameter logic [DATA_W-1:0] ADDR_HEX = DATA_W'(DEF_ADDR_HEX),
   parameter logic [4*NUM_HEX-1:0] HEX_RST = (4*NUM_HEX)'(16'hBFFF)
) (
   input  logic                    I_CLOCK,
   input  logic                    I_RESET,
   input  logic                    I_Valid,
   input  logic [OPCODE_WIDTH-1:0] I_Opcode,
   input  logic [3:0]              I_DestRegIdx,
   input  logic [DATA_W-1:0]       I_DestValue,
   input  logic [2:0]              I_CCValue,
   input  logic [DATA_W-1:0]       I_MARValue,
   input  logic [DATA_W-1:0]       I_MDRValue,
   input  logic                    I_RegWEn,
   input  logic                    I_CCWEn,
   input  logic                    I_DownStall,
   output logic                    O_Stall,
   output logic                    O_Valid,
   output logic [OPCODE_WIDTH-1:0] O_Opcode,
   output logic [3:0]              O_DestRegIdx,
   output logic [DATA_W-1:0]       O_DestValue,
   output logic [2:0]              O_CCValue,
   output logic                    O_RegWEn,
   output logic                    O_CCWEn,
   output logic                    O_AddrErr,
   output logic [9:0]              O_LEDR,
   output logic [7:0]              O_LEDG,
   output logic [7*NUM_HEX-1:0]    O_HEX
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [DATA_W:0] DEPTH_W = (DATA_W+1)'(DEPTH);
   state_t state, state_n;
   logic [3:0] cnt;
   logic [AW-1:0] l_waddr;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] waddr, mrd, ld_val;
   logic hit, oor, is_ld, is_st, hold, accept, ram_wait, rwe_q, cwe_q;

   function automatic logic [2:0] cc_of(input logic [DATA_W-1:0] v);
      return v[DATA_W-1] ? CC_N : (v == '0) ? CC_Z : CC_P;
   endfunction

   mem_stage_mmio_regs #(
      .DATA_W(DATA_W), .NUM_HEX(NUM_HEX), .ADDR_LEDR(ADDR_LEDR),
      .ADDR_LEDG(ADDR_LEDG), .ADDR_HEX(ADDR_HEX), .HEX_RST(HEX_RST)
   ) u_regs (
      .clk(I_CLOCK), .rst(I_RESET), .we(accept && is_st), .addr(I_MARValue),
      .wdata(I_MDRValue), .hit(hit), .rdata(mrd), .ledr(O_LEDR), .ledg(O_LEDG), .hex(O_HEX)
   );

   assign waddr = {1'b0, I_MARValue[DATA_W-1:1]};
   assign is_ld = I_Opcode == OP_LDW;
   assign is_st = I_Opcode == OP_STW;
   assign oor = !hit && ({1'b0, waddr} >= DEPTH_W);
   assign hold = O_Valid && I_DownStall;
   assign O_Stall = (state == ST_WAIT) || hold;
   assign accept = I_Valid && !O_Stall;
   // only in-range RAM loads pay the read latency; MMIO and out-of-range loads answer at once
   assign ram_wait = is_ld && !hit && !oor && (READ_LAT != 0);
   assign ld_val = hit ? mrd : oor ? '0 : mem[waddr[AW-1:0]];
   assign O_RegWEn = O_Valid && rwe_q;
   assign O_CCWEn = O_Valid && cwe_q;

   always_comb begin
      state_n = state;
      state_n = (state == ST_WAIT) ? ((cnt == 4'd1) ? ST_RUN : ST_WAIT)
                                   : ((accept && ram_wait) ? ST_WAIT : ST_RUN);
   end

   always_ff @(negedge I_CLOCK or posedge I_RESET)
      if (I_RESET) state <= ST_RUN;
      else state <= state_n;

   always_ff @(negedge I_CLOCK or posedge I_RESET)
      if (I_RESET) begin
         cnt <= '0;
         l_waddr <= '0;
         O_Valid <= 1'b0;
         O_Opcode <= '0;
         O_DestRegIdx <= '0;
         O_DestValue <= '0;
         O_CCValue <= CC_Z;
         rwe_q <= 1'b0;
         cwe_q <= 1'b0;
         O_AddrErr <= 1'b0;
      end else if (state == ST_WAIT) begin
         cnt <= cnt - 4'd1;
         if (cnt == 4'd1) begin
            O_Valid <= 1'b1;
            O_DestValue <= mem[l_waddr];
            O_CCValue <= cc_of(mem[l_waddr]);
         end
      end else if (accept) begin
         O_Opcode <= I_Opcode;
         O_DestRegIdx <= I_DestRegIdx;
         rwe_q <= I_RegWEn && !is_st;
         cwe_q <= I_CCWEn || is_ld;
         O_Valid <= !ram_wait;
         O_DestValue <= is_ld ? ld_val : I_DestValue;
         O_CCValue <= is_ld ? cc_of(ld_val) : I_CCValue;
         cnt <= 4'(READ_LAT);
         l_waddr <= waddr[AW-1:0];
         if ((is_ld || is_st) && oor) O_AddrErr <= 1'b1;
      end else if (!hold) O_Valid <= 1'b0;

   always_ff @(negedge I_CLOCK)
      if (accept && is_st && !hit && !oor) mem[waddr[AW-1:0]] <= I_MDRValue;
endmodule

// File: tb/tb_mem_stage_mmio.sv
// tb_mem_stage_mmio: directed stimulus with a result scoreboard checked by an output monitor
module tb_mem_stage_mmio;
   import mem_stage_mmio_pkg::*;
   localparam logic [3:0] OP_ADD = 4'd1;
   localparam logic [27:0] HEX_RESET = {7'h03, 7'h0E, 7'h0E, 7'h0E};
   typedef struct packed {
      logic [3:0] op;
      logic [3:0] dst;
      logic [15:0] val;
      logic [2:0] cc;
      logic rwe;
      logic cwe;
      logic cv;
   } exp_t;

   logic clk = 1'b0;
   logic I_RESET, I_Valid, I_RegWEn, I_CCWEn, I_DownStall;
   logic [3:0] I_Opcode, I_DestRegIdx;
   logic [15:0] I_DestValue, I_MARValue, I_MDRValue;
   logic [2:0] I_CCValue;
   logic O_Stall, O_Valid, O_RegWEn, O_CCWEn, O_AddrErr;
   logic [3:0] O_Opcode, O_DestRegIdx;
   logic [15:0] O_DestValue;
   logic [2:0] O_CCValue;
   logic [9:0] O_LEDR;
   logic [7:0] O_LEDG;
   logic [27:0] O_HEX;
   int n_chk = 0, n_fail = 0, last_stalls = 0;
   exp_t q[$];

   always #5 clk = ~clk;

   mem_stage_mmio #(.DEPTH(256), .READ_LAT(2)) dut (
      .I_CLOCK(clk), .I_RESET(I_RESET), .I_Valid(I_Valid), .I_Opcode(I_Opcode),
      .I_DestRegIdx(I_DestRegIdx), .I_DestValue(I_DestValue), .I_CCValue(I_CCValue),
      .I_MARValue(I_MARValue), .I_MDRValue(I_MDRValue), .I_RegWEn(I_RegWEn),
      .I_CCWEn(I_CCWEn), .I_DownStall(I_DownStall), .O_Stall(O_Stall), .O_Valid(O_Valid),
      .O_Opcode(O_Opcode), .O_DestRegIdx(O_DestRegIdx), .O_DestValue(O_DestValue),
      .O_CCValue(O_CCValue), .O_RegWEn(O_RegWEn), .O_CCWEn(O_CCWEn), .O_AddrErr(O_AddrErr),
      .O_LEDR(O_LEDR), .O_LEDG(O_LEDG), .O_HEX(O_HEX)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic exp_t mk(input logic [3:0] op, dst, input logic [15:0] val,
                               input logic [2:0] cc, input logic rwe, cwe, cv);
      mk = {op, dst, val, cc, rwe, cwe, cv};
   endfunction

   // called just after a falling edge; returns just after the edge that accepted the instruction
   task automatic send(input logic [3:0] op, dst, input logic [15:0] dv, input logic [2:0] cc,
                       input logic [15:0] mar, mdr, input logic rwe, cwe, input exp_t e, input bit push);
      int n = 0;
      bit acc = 1'b0;
      I_Valid = 1'b1; I_Opcode = op; I_DestRegIdx = dst; I_DestValue = dv; I_CCValue = cc;
      I_MARValue = mar; I_MDRValue = mdr; I_RegWEn = rwe; I_CCWEn = cwe;
      while (!acc && n < 50) begin
         @(posedge clk);
         acc = !O_Stall;
         @(negedge clk);
         #1;
         if (!acc) n++;
      end
      I_Valid = 1'b0;
      last_stalls = n;
      if (!acc) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: op %h mar %h never accepted", op, mar);
      end else if (push) q.push_back(e);
   endtask

   task automatic st(input logic [15:0] mar, mdr);
      send(OP_STW, 4'd0, 16'h0, CC_P, mar, mdr, 1'b1, 1'b1, mk(OP_STW, 4'd0, 16'h0, CC_P, 1'b0, 1'b1, 1'b0), 1'b1);
   endtask

   task automatic ld(input logic [15:0] mar, input logic [3:0] dst, input logic [15:0] val, input logic [2:0] cc);
      send(OP_LDW, dst, 16'hFFFF, 3'b000, mar, 16'h0, 1'b1, 1'b0, mk(OP_LDW, dst, val, cc, 1'b1, 1'b1, 1'b1), 1'b1);
   endtask

   task automatic alu(input logic [3:0] dst, input logic [15:0] dv, input logic [2:0] cc, input logic rwe, cwe);
      send(OP_ADD, dst, dv, cc, 16'h0400, 16'h0, rwe, cwe, mk(OP_ADD, dst, dv, cc, rwe, cwe, 1'b1), 1'b1);
   endtask

   always @(posedge clk)
      if (!I_RESET && O_Valid && !I_DownStall) begin
         exp_t e;
         if (q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_output: dst %h value %h with empty scoreboard", O_DestRegIdx, O_DestValue);
         end else begin
            e = q.pop_front();
            chk($sformatf("result_dst%0d", e.dst),
                {O_Opcode, O_DestRegIdx, e.cv ? O_DestValue : e.val, O_CCValue, O_RegWEn, O_CCWEn},
                {e.op, e.dst, e.val, e.cc, e.rwe, e.cwe});
         end
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w = 0;
      I_RESET = 1'b1; I_Valid = 1'b0; I_DownStall = 1'b0; I_Opcode = '0; I_DestRegIdx = '0;
      I_DestValue = '0; I_CCValue = '0; I_MARValue = '0; I_MDRValue = '0; I_RegWEn = 1'b0; I_CCWEn = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_valid", O_Valid, 1'b0);
      chk("rst_stall", O_Stall, 1'b0);
      chk("rst_leds", {O_LEDR, O_LEDG}, {10'h3FF, 8'hFF});
      chk("rst_hex", O_HEX, HEX_RESET);
      chk("rst_out", {O_DestValue, O_CCValue, O_RegWEn, O_CCWEn, O_AddrErr}, {16'h0, CC_Z, 3'b000});
      I_RESET = 1'b0;
      @(negedge clk);
      #1;
      st(16'h0010, 16'h8001);
      ld(16'h0010, 4'd3, 16'h8001, CC_N);
      st(16'h0020, 16'h0000);
      chk("ld_bubbles", last_stalls, 2);
      st(16'h0030, 16'h7FFF);
      chk("st_throughput", last_stalls, 0);
      ld(16'h0020, 4'd4, 16'h0000, CC_Z);
      ld(16'h0030, 4'd5, 16'h7FFF, CC_P);
      chk("ld_bubbles_b2b", last_stalls, 2);
      st(16'h01FE, 16'h5555);
      st(16'h03FE, 16'h1234);
      chk("hex_digits", O_HEX, {7'h79, 7'h24, 7'h30, 7'h19});
      ld(16'h03FE, 4'd6, 16'h1234, CC_P);
      ld(16'h01FE, 4'd7, 16'h5555, CC_P);
      chk("mmio_no_bubble", last_stalls, 0);
      st(16'h03FC, 16'hFEAA);
      st(16'h03FD, 16'h00C3);
      chk("led_regs", {O_LEDR, O_LEDG}, {10'h2AA, 8'hC3});
      ld(16'h03FD, 4'd8, 16'h00C3, CC_P);
      chk("addr_err_clear", O_AddrErr, 1'b0);
      st(16'h0000, 16'h0ABC);
      st(16'h0400, 16'hDEAD);
      chk("addr_err_set", O_AddrErr, 1'b1);
      ld(16'h0400, 4'd9, 16'h0000, CC_Z);
      ld(16'h0000, 4'd10, 16'h0ABC, CC_P);
      alu(4'd11, 16'h4321, CC_P, 1'b1, 1'b1);
      alu(4'd12, 16'h8000, CC_Z, 1'b0, 1'b0);
      chk("addr_err_sticky", O_AddrErr, 1'b1);
      repeat (2) @(negedge clk);
      #1;
      I_DownStall = 1'b1;
      alu(4'd13, 16'hAAAA, CC_N, 1'b1, 1'b1);
      fork
         alu(4'd14, 16'h5555, CC_P, 1'b1, 1'b0);
         begin
            repeat (3) begin
               @(posedge clk);
               chk("bp_stall", O_Stall, 1'b1);
               chk("bp_hold", {O_Valid, O_DestRegIdx, O_DestValue}, {1'b1, 4'd13, 16'hAAAA});
            end
            @(negedge clk);
            #1 I_DownStall = 1'b0;
         end
      join
      chk("bp_release", last_stalls, 3);
      repeat (2) @(negedge clk);
      #1;
      send(OP_LDW, 4'd15, 16'h0, 3'b000, 16'h0010, 16'h0, 1'b1, 1'b0, mk(OP_LDW, 4'd15, 16'h0, CC_Z, 1'b1, 1'b1, 1'b1), 1'b0);
      @(posedge clk);
      chk("wait_stall", O_Stall, 1'b1);
      #2 I_RESET = 1'b1;
      #1;
      chk("abort_stall", O_Stall, 1'b0);
      chk("abort_valid", O_Valid, 1'b0);
      chk("abort_leds", {O_LEDR, O_LEDG}, {10'h3FF, 8'hFF});
      chk("abort_hex", O_HEX, HEX_RESET);
      chk("abort_err", O_AddrErr, 1'b0);
      repeat (2) @(negedge clk);
      #1 I_RESET = 1'b0;
      repeat (5) @(negedge clk);
      #1;
      chk("abort_no_output", O_Valid, 1'b0);
      ld(16'h0010, 4'd1, 16'h8001, CC_N);
      while (q.size() != 0 && w < 50) begin
         @(negedge clk);
         w++;
      end
      chk("drain", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
